// File: rtl/alu_shift_pkg.sv
// Shared definitions for the iterative ALU shift path:
// op encodings, FSM states and default widths.
package alu_shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle of the shift sequencer.
// master = ALU issue side, slave = shift unit.
interface shift_sequencer_if
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt,
    output in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt,
    input  in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_step_1.sv
// One-bit shift step: d -> q by SLL/SRL/SRA.
// Ports: d (operand), op (2-bit op), q (result).
module shift_step_1
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = {d[WIDTH-2:0], 1'b0};
    // reserved op 11 falls to the SLL default
    unique case (1'b1)
      (op == SHOP_SLL): q = {d[WIDTH-2:0], 1'b0};
      (op == SHOP_SRL): q = {1'b0, d[WIDTH-1:1]};
      (op == SHOP_SRA): q = {d[WIDTH-1], d[WIDTH-1:1]};
      default:          q = {d[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle shifter: one bit per cycle, valid/ready in and out.
// Ports: clock, reset (sync, low), bus (slave), busy.
module shift_sequencer
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  shift_sequencer_if.slave   bus,
  output logic               busy
);

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] count_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   step_q;
  logic               accept;

  shift_step_1 #(
    .WIDTH (WIDTH)
  ) u_step (
    .d  (data_r),
    .op (op_r),
    .q  (step_q)
  );

  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          // zero shift skips straight to the result
          state_n = (bus.in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      (state == ST_SHIFT): begin
        if (count_r == SHAMT_W'(1))
          state_n = ST_DONE;
      end
      (state == ST_DONE): begin
        bus.out_valid = 1'b1;
        bus.out_data  = data_r;
        if (bus.out_ready)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      data_r  <= '0;
      count_r <= '0;
      op_r    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_r  <= bus.in_data;
        count_r <= bus.in_shamt;
        op_r    <= bus.in_op;
      end else if (state == ST_SHIFT) begin
        data_r  <= step_q;
        count_r <= count_r - SHAMT_W'(1);
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a timeline model
// checked every cycle plus literal expectations.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   vectors;
  int   miscompares;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(
    input logic [1:0] op, input logic [31:0] d,
    input logic [4:0] sh);
    case (op)
      2'b01:   return d >> sh;
      2'b10:   return $signed(d) >>> sh;
      default: return d << sh;
    endcase
  endfunction

  // Timeline model: a job accepted in cycle c presents its
  // result from cycle c+shamt+1 until the output handshake.
  bit          armed;
  bit          job;
  int          rdy_cyc;
  logic [31:0] res;

  initial begin
    armed = 0;
    job   = 0;
  end

  always @(negedge clk) begin
    bit          e_ov;
    e_ov = job && (cyc >= rdy_cyc);
    if (armed) begin
      chk("m_in_ready", 32'(bus.in_ready), 32'(!job));
      chk("m_out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("m_out_data", bus.out_data, e_ov ? res : 32'h0);
      chk("m_busy", 32'(busy), 32'(job));
    end
    if (reset === 1'b0) begin
      job   = 0;
      armed = 1;
    end else if (armed) begin
      if (e_ov && bus.out_ready === 1'b1)
        job = 0;
      else if (!job && bus.in_valid === 1'b1) begin
        job     = 1;
        rdy_cyc = cyc + 1 + int'(bus.in_shamt);
        res     = ref_shift(bus.in_op, bus.in_data,
                            bus.in_shamt);
      end
    end
  end

  task automatic accept_op(input logic [1:0] op,
                           input logic [31:0] d,
                           input logic [4:0] sh,
                           output int acc);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = sh;
    acc = -1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready never 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc,
                             input logic [31:0] exp_d,
                             input int exp_lat,
                             input bit churn);
    bit got;
    got = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        got = 1;
        break;
      end
      if (churn) begin
        #2;
        bus.in_data  = $urandom;
        bus.in_shamt = 5'($urandom);
        bus.in_op    = 2'($urandom);
      end
    end
    if (!got) begin
      miscompares++;
      $display("FAIL result_timeout: out_valid never 1");
    end else begin
      chk("latency", 32'(cyc - acc), 32'(exp_lat));
      chk("result", bus.out_data, exp_d);
    end
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_op    = '0;
    @(negedge clk);
    chk("idle_ov", 32'(bus.out_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_ready", 32'(bus.in_ready), 32'h1);
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] d,
                       input logic [4:0] sh,
                       input bit churn,
                       input logic [31:0] exp_d,
                       input int exp_lat);
    int acc;
    accept_op(op, d, sh, acc);
    wait_result(acc, exp_d, exp_lat, churn);
    to_idle();
  endtask

  initial begin
    int acc;
    int acc2;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_op    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_op(2'b00, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 32);
    do_op(2'b10, 32'h8000_0000, 5'd4, 0, 32'hF800_0000, 5);
    do_op(2'b01, 32'h8000_0000, 5'd4, 0, 32'h0800_0000, 5);
    do_op(2'b10, 32'h7FFF_FFF0, 5'd4, 0, 32'h07FF_FFFF, 5);
    do_op(2'b00, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, 1);
    do_op(2'b01, 32'hF000_0000, 5'd8, 1, 32'h00F0_0000, 9);
    do_op(2'b11, 32'h0000_0001, 5'd2, 0, 32'h0000_0004, 3);
    do_op(2'b10, 32'h8765_4321, 5'd31, 0, 32'hFFFF_FFFF, 32);
    do_op(2'b01, 32'hFFFF_FFFF, 5'd1, 0, 32'h7FFF_FFFF, 2);

    // backpressure with a pending request behind it
    bus.out_ready = 1'b0;
    accept_op(2'b00, 32'h0000_0003, 5'd1, acc);
    wait_result(acc, 32'h0000_0006, 2, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_op    = 2'b00;
    bus.in_shamt = 5'd0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_ov", 32'(bus.out_valid), 32'h1);
      chk("bp_data", bus.out_data, 32'h0000_0006);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_ov", 32'(bus.out_valid), 32'h0);
    chk("bp_idle_ready", 32'(bus.in_ready), 32'h1);
    acc2 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(acc2, 32'hFFFF_FFFF, 1, 0);
    to_idle();

    // reset in the middle of a long shift
    accept_op(2'b00, 32'h0000_0001, 5'd20, acc);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mr_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_out_data", bus.out_data, 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    repeat (30) begin
      @(negedge clk);
      chk("mr_no_result", 32'(bus.out_valid), 32'h0);
    end

    do_op(2'b00, 32'h0000_0101, 5'd3, 0, 32'h0000_0808, 4);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the ALU: reuses a single 1-bit shift step (SLL/SRL/SRA) iteratively instead of a full 5-stage barrel shifter.
- Accepts an operand, a shift amount and an op through a valid/ready handshake, and shifts one bit per cycle.
- Presents the result through a valid/ready output handshake.
- Sits between the ALU issue logic and the ALU result mux, giving an area-reduced shift path for the multdiv-style multicycle slot.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the clock edge, 0 = reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: data_r[WIDTH-1:0], count_r[SHAMT_W-1:0], op_r[1:0].
- Reset (reset==0 at an edge): state=IDLE, data_r=0, count_r=0, op_r=0. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- Reset mid-operation aborts it. No result is emitted, and the next cycle is IDLE.
- IDLE:
  - in_ready=1.
  - Acceptance on in_valid & in_ready: latch data_r=in_data, count_r=in_shamt, op_r=in_op.
  - Next state is DONE if in_shamt==0, else SHIFT.
  - No in_valid: stay IDLE, registers unchanged.
- SHIFT:
  - in_ready=0. Each edge applies data_r <= step(data_r, op_r) and count_r <= count_r-1.
  - When count_r==1 before the edge, next state is DONE.
- step definitions:
  - SLL: {d[WIDTH-2:0],1'b0}.
  - SRL: {1'b0,d[WIDTH-1:1]}.
  - SRA: {d[WIDTH-1],d[WIDTH-1:1]}.
  - Reserved op 11 behaves as SLL.
- DONE:
  - out_valid=1, out_data=data_r, in_ready=0.
  - out_ready=1 moves to IDLE at that edge. out_valid drops the next cycle.
  - out_ready=0 holds state; out_data stays stable.
- out_data=0 whenever out_valid=0. It is driven from data_r only in DONE.
- Latency: handshake in cycle 0 puts out_valid high in cycle in_shamt+1 (shamt=0 gives cycle 1; shamt=31 gives cycle 32).
- Throughput: there is no accept in DONE, so back-to-back ops take at least shamt+2 cycles.
- Operand inputs are sampled only at acceptance. Changes on in_data, in_shamt or in_op during SHIFT/DONE are ignored.
- in_valid while in_ready=0 is ignored. The requester must hold the request until accepted.
- Same-cycle out_ready and in_valid in DONE: only the output handshake completes. The new request is accepted no earlier than the next cycle (IDLE).
- busy = (state != IDLE).

Decomposition:
- Shared package alu_shift_pkg holds:
  - op encodings SHOP_SLL=2'b00, SHOP_SRL=2'b01, SHOP_SRA=2'b10.
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - default WIDTH/SHAMT_W constants.
- One combinational sub-module, shift_step_1 (inputs d[WIDTH-1:0], op[1:0]; output q[WIDTH-1:0]), implements the single-bit step.
- The sequencer holds the FSM, count and data registers only.

Test Plan:
- SLL 0x0000_0001, shamt 31, out_ready=1: handshake cycle 0 -> out_valid first high cycle 32, out_data=0x8000_0000, IDLE at cycle 33.
- SRA 0x8000_0000, shamt 4 -> out_valid cycle 5, out_data=0xF800_0000. Same with SRL -> 0x0800_0000. SRA 0x7FFF_FFF0 shamt 4 -> 0x07FF_FFFF.
- shamt 0, SLL 0xDEAD_BEEF -> out_valid cycle 1, out_data=0xDEAD_BEEF, no SHIFT state visited.
- Backpressure: SLL 0x0000_0003 shamt 1, out_ready=0 for 10 cycles -> out_valid stays 1, out_data=0x0000_0006 stable, in_ready=0. A new in_valid with 0xFFFF_FFFF is not accepted. Raise out_ready -> IDLE next cycle, then the pending request is accepted.
- Reset mid-op: start SLL shamt 20, drive reset=0 at cycle 8 for one edge -> next cycle IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, no result ever emitted.
- Input churn: accept SRL 0xF000_0000 shamt 8, toggle in_data/in_shamt/in_op every cycle during SHIFT -> out_data=0x00F0_0000 at cycle 9. Op 11 with 0x1 shamt 2 -> 0x4.
